// File: rtl/rf_debug_dumper_pkg.sv
// rtl/rf_debug_dumper_pkg.sv - shared types and defaults for the register file debug dumper
//
// Purpose: FSM state encoding and the default geometry shared with RegFile.
// Ports:   none (package).
package rf_debug_dumper_pkg;

  // Default geometry; must track the RegFile instance being dumped.
  localparam int RF_WIDTH   = 32;
  localparam int RF_DEPTH_B = 5;
  localparam int RF_DEPTH   = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } dump_state_t;

endpackage

// File: rtl/rf_debug_dumper.sv
// rtl/rf_debug_dumper.sv - walks the RegFile debug port and streams {index, value} beats
//
// Purpose: on dump_start, reads every register index 0..DEPTH-1 through the
//          debug read port and emits one beat per register on a valid/ready
//          stream (zero-valued registers optionally suppressed).
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   dump_start, dump_abort    level controls (start sampled in IDLE only)
//   debug_reg_ra/_rd          RegFile debug read address / combinational data
//   out_valid/ready/idx/data  beat stream
//   busy                      dump in progress (FETCH/SEND)
//   done                      one-cycle pulse after the last index
module rf_debug_dumper
  import rf_debug_dumper_pkg::*;
#(
  parameter int WIDTH     = RF_WIDTH,
  parameter int DEPTH_B   = RF_DEPTH_B,
  parameter int DEPTH     = RF_DEPTH,
  parameter int SKIP_ZERO = 0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               dump_start,
  input  logic               dump_abort,
  output logic [DEPTH_B-1:0] debug_reg_ra,
  input  logic [WIDTH-1:0]   debug_reg_rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DEPTH_B-1:0] out_idx,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy,
  output logic               done
);

  localparam logic [DEPTH_B-1:0] LAST_IDX = DEPTH_B'(DEPTH - 1);

  dump_state_t        state_q, state_d;
  logic [DEPTH_B-1:0] cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [DEPTH_B-1:0] out_idx_q, out_idx_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;

  logic at_last;
  logic skip_beat;

  // End test is an equality, so cnt never wraps even when DEPTH < 2**DEPTH_B.
  assign at_last   = (cnt_q == LAST_IDX);
  assign skip_beat = (SKIP_ZERO != 0) && (debug_reg_rd == '0);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    if (dump_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (dump_start) state_d = ST_FETCH;
        ST_FETCH: begin
          if (skip_beat) state_d = at_last ? ST_DONE : ST_FETCH;
          else           state_d = ST_SEND;
        end
        ST_SEND:  if (out_ready) state_d = at_last ? ST_DONE : ST_FETCH;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath next values. The read value is captured in FETCH only, so a
  // later pipeline write to the same index is not seen by this dump.
  always_comb begin
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    if (dump_abort) begin
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (dump_start) cnt_d = '0;
        ST_FETCH: begin
          out_data_d = debug_reg_rd;
          out_idx_d  = cnt_q;
          if (skip_beat) begin
            if (!at_last) cnt_d = cnt_q + DEPTH_B'(1);
          end else begin
            out_valid_d = 1'b1;
          end
        end
        ST_SEND: begin
          // out_valid_q is always high here, so out_ready alone completes the beat.
          if (out_ready) begin
            out_valid_d = 1'b0;
            if (!at_last) cnt_d = cnt_q + DEPTH_B'(1);
          end
        end
        ST_DONE: cnt_d = '0;
        default: cnt_d = '0;
      endcase
    end
  end

  // Outputs decoded from registered state only, so they are glitch-free.
  always_comb begin
    busy = (state_q == ST_FETCH) || (state_q == ST_SEND);
    done = (state_q == ST_DONE);
  end

  assign debug_reg_ra = cnt_q;
  assign out_valid    = out_valid_q;
  assign out_idx      = out_idx_q;
  assign out_data     = out_data_q;

endmodule

// File: tb/tb_rf_debug_dumper.sv
// tb/tb_rf_debug_dumper.sv - randomized self-checking bench for rf_debug_dumper
module tb_rf_debug_dumper;

  typedef logic [36:0] beat_t;
  typedef beat_t beat_q_t[$];

  logic        clk;
  logic        rstn;
  logic        start_i [2];
  logic        abort_i [2];
  logic        ready_i [2];
  logic [4:0]  ra_o    [2];
  logic [31:0] rd_i    [2];
  logic        valid_o [2];
  logic [4:0]  idx_o   [2];
  logic [31:0] data_o  [2];
  logic        busy_o  [2];
  logic        done_o  [2];

  logic [31:0] rf [32];

  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  beat_t got_q [2][$];
  int    done_cnt [2];
  int    hs_cyc   [2];
  int    done_cyc [2];

  // Register file model: x0 reads as zero, read is combinational.
  assign rd_i[0] = (ra_o[0] == 5'd0) ? 32'd0 : rf[ra_o[0]];
  assign rd_i[1] = (ra_o[1] == 5'd0) ? 32'd0 : rf[ra_o[1]];

  rf_debug_dumper #(.WIDTH(32), .DEPTH_B(5), .DEPTH(32), .SKIP_ZERO(0)) dut0 (
    .clk(clk), .rstn(rstn), .dump_start(start_i[0]), .dump_abort(abort_i[0]),
    .debug_reg_ra(ra_o[0]), .debug_reg_rd(rd_i[0]), .out_valid(valid_o[0]),
    .out_ready(ready_i[0]), .out_idx(idx_o[0]), .out_data(data_o[0]),
    .busy(busy_o[0]), .done(done_o[0])
  );

  rf_debug_dumper #(.WIDTH(32), .DEPTH_B(5), .DEPTH(32), .SKIP_ZERO(1)) dut1 (
    .clk(clk), .rstn(rstn), .dump_start(start_i[1]), .dump_abort(abort_i[1]),
    .debug_reg_ra(ra_o[1]), .debug_reg_rd(rd_i[1]), .out_valid(valid_o[1]),
    .out_ready(ready_i[1]), .out_idx(idx_o[1]), .out_data(data_o[1]),
    .busy(busy_o[1]), .done(done_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake / done monitor, sampled away from the active edge.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rstn && !abort_i[u] && valid_o[u] && ready_i[u]) begin
        got_q[u].push_back({idx_o[u], data_o[u]});
        hs_cyc[u] = cyc;
      end
      if (done_o[u]) begin
        done_cnt[u] = done_cnt[u] + 1;
        done_cyc[u] = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Expected stream: every index in order, zero values dropped when skipping.
  function automatic beat_q_t model(input bit skip);
    beat_q_t q;
    logic [31:0] v;
    for (int i = 0; i < 32; i++) begin
      v = (i == 0) ? 32'd0 : rf[i];
      if (!(skip && v == 32'd0)) q.push_back({5'(i), v});
    end
    return q;
  endfunction

  task automatic run_dump(input int u, input int pct, input bit bp3, input bit wr9, input string tag);
    beat_q_t     exp;
    int          n;
    bit          bp_seen;
    bit          wr_seen;
    logic [31:0] snap;
    exp = model(u == 1);
    got_q[u].delete();
    done_cnt[u] = 0;
    bp_seen = 0;
    wr_seen = 0;
    @(posedge clk); #1;
    start_i[u] = 1'b1;
    ready_i[u] = 1'b1;
    @(posedge clk); #1;
    start_i[u] = 1'b0;
    check({tag, "_busy_after_start"}, 64'(busy_o[u]), 64'd1);
    n = 0;
    while (done_cnt[u] == 0 && n < 3000) begin
      ready_i[u] = ($urandom_range(99) < pct);
      if (bp3 && !bp_seen && valid_o[u] && idx_o[u] == 5'd3) begin
        bp_seen = 1;
        snap = data_o[u];
        ready_i[u] = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check({tag, "_bp_hold"}, {26'd0, valid_o[u], idx_o[u], data_o[u]}, {26'd0, 1'b1, 5'd3, snap});
          @(posedge clk); #1;
        end
        ready_i[u] = 1'b1;
      end
      if (wr9 && !wr_seen && valid_o[u] && idx_o[u] == 5'd9) begin
        wr_seen = 1;
        rf[9] = 32'h0000_BEEF;
      end
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done_in_time"}, 64'(n < 3000), 64'd1);
    ready_i[u] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_once"}, 64'(done_cnt[u]), 64'd1);
    check({tag, "_idle_busy"}, 64'(busy_o[u]), 64'd0);
    check({tag, "_beat_count"}, 64'(got_q[u].size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got_q[u].size(); i++)
      check($sformatf("%s_beat%0d", tag, i), 64'(got_q[u][i]), 64'(exp[i]));
    if (exp.size() > 0 && exp[exp.size()-1][36:32] == 5'd31)
      check({tag, "_done_timing"}, 64'(done_cyc[u] - hs_cyc[u]), 64'd1);
  endtask

  task automatic wait_beat(input int u, input logic [4:0] idx, input string tag);
    int n;
    n = 0;
    while (!(valid_o[u] && idx_o[u] == idx) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_reached"}, 64'(n < 500), 64'd1);
  endtask

  initial begin
    beat_q_t dummy;
    rstn = 1'b0;
    for (int u = 0; u < 2; u++) begin
      start_i[u] = 1'b0; abort_i[u] = 1'b0; ready_i[u] = 1'b0;
      done_cnt[u] = 0; hs_cyc[u] = 0; done_cyc[u] = 0;
    end
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(valid_o[0]), 64'd0);
    check("rst_idx",   64'(idx_o[0]),   64'd0);
    check("rst_data",  64'(data_o[0]),  64'd0);
    check("rst_busy",  64'(busy_o[0]),  64'd0);
    check("rst_done",  64'(done_o[0]),  64'd0);
    check("rst_ra",    64'(ra_o[0]),    64'd0);
    rstn = 1'b1;

    run_dump(0, 100, 0, 0, "full");
    dummy = model(0);
    check("full_last_data", 64'(dummy[31][31:0]), 64'h11F);

    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    run_dump(0, 100, 1, 0, "bp");

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      run_dump(0, 60, 0, 0, $sformatf("rand%0d", k));
    end

    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rf[5] = 32'hDEAD;
    rf[31] = 32'h1;
    run_dump(1, 100, 0, 0, "skip");

    for (int i = 0; i < 32; i++) rf[i] = ($urandom_range(1) == 1) ? $urandom : 32'd0;
    rf[31] = 32'd0;
    run_dump(1, 70, 0, 0, "skiprand");

    // Abort while beat 10 is pending.
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    done_cnt[0] = 0;
    @(posedge clk); #1;
    start_i[0] = 1'b1; ready_i[0] = 1'b1;
    @(posedge clk); #1;
    start_i[0] = 1'b0;
    wait_beat(0, 5'd10, "abort");
    ready_i[0] = 1'b0;
    abort_i[0] = 1'b1;
    @(posedge clk); #1;
    abort_i[0] = 1'b0;
    check("abort_valid", 64'(valid_o[0]), 64'd0);
    check("abort_busy",  64'(busy_o[0]),  64'd0);
    check("abort_ra",    64'(ra_o[0]),    64'd0);
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt[0]), 64'd0);
    run_dump(0, 80, 0, 0, "after_abort");

    // Asynchronous reset in the middle of a dump.
    @(posedge clk); #1;
    start_i[0] = 1'b1; ready_i[0] = 1'b1;
    @(posedge clk); #1;
    start_i[0] = 1'b0;
    wait_beat(0, 5'd7, "mrst");
    #2;
    rstn = 1'b0;
    #1;
    check("mrst_valid", 64'(valid_o[0]), 64'd0);
    check("mrst_idx",   64'(idx_o[0]),   64'd0);
    check("mrst_data",  64'(data_o[0]),  64'd0);
    check("mrst_busy",  64'(busy_o[0]),  64'd0);
    check("mrst_ra",    64'(ra_o[0]),    64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    run_dump(0, 100, 0, 0, "after_rst");

    // Write to x9 after its fetch: old value in this dump, new in the next.
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[9] = 32'h1234_5678;
    run_dump(0, 100, 0, 1, "snap1");
    run_dump(0, 100, 0, 0, "snap2");
    if (got_q[0].size() > 9) check("snap2_x9", 64'(got_q[0][9]), {27'd0, 5'd9, 32'h0000_BEEF});
    else check("snap2_x9_present", 64'(got_q[0].size()), 64'd32);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
